adc_multi_capture: RTL

Parametrised capture engine for serial pixel ADCs: drives one shared CS/SCLK pair to NCH ADCs and shifts in all NCH data lines in parallel. It extracts the sample field from each frame and packs one NCH-channel word per conversion into an internal FWFT buffer with valid/ready readout. The block sits between the pixel-array sequencer (which issues start requests) and the PSRAM/APB data path, and replaces the fixed three-channel px0/px1/px2 capture logic.

---
 rtl/adc_multi_capture_pkg.sv | 36 +++
 rtl/adc_sync_fifo.sv | 63 ++++++
 rtl/adc_multi_capture.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adc_multi_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_multi_capture_pkg
// Brief    : Shared state encoding, default parameters and frame field helper
//            for the multi-channel ADC capture engine.
// Revision : 1.0
// ============================================================================
package adc_multi_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_QUIET = 3'd3,
        ST_PUSH  = 3'd4
    } state_t;

    localparam int c_DEF_NCH        = 3;
    localparam int c_DEF_SAMPLE_W   = 12;
    localparam int c_DEF_FRAME_BITS = 16;
    localparam int c_DEF_LEAD_BITS  = 4;
    localparam int c_DEF_CLKDIV     = 2;
    localparam int c_DEF_QUIET_CYC  = 4;
    localparam int c_DEF_DEPTH      = 4;

    // Returns frame[msb -: width], right-aligned (frames up to 64 bits, fields up to 32)
    function automatic logic [31:0] frame_field(input logic [63:0] frame,
                                                input int          msb,
                                                input int          width);
        logic [63:0] v;
        v = frame >> (msb - width + 1);
        return v[31:0] & ((32'd1 << width) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : adc_sync_fifo
// Brief    : First-word-fall-through synchronous FIFO with flush; a pop frees
//            its slot for a push in the same cycle.
// Revision : 1.0
// ============================================================================
module adc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);
    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == c_FULL);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && o_valid;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_multi_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_multi_capture
// Brief    : Shared CS/SCLK sequencer for NCH serial ADCs; shifts all lines in
//            parallel and buffers one packed NCH-channel word per conversion.
// Revision : 1.0
// ============================================================================
module adc_multi_capture
    import adc_multi_capture_pkg::*;
#(
    parameter int NCH        = c_DEF_NCH,
    parameter int SAMPLE_W   = c_DEF_SAMPLE_W,
    parameter int FRAME_BITS = c_DEF_FRAME_BITS,
    parameter int LEAD_BITS  = c_DEF_LEAD_BITS,
    parameter int CLKDIV     = c_DEF_CLKDIV,
    parameter int QUIET_CYC  = c_DEF_QUIET_CYC,
    parameter int DEPTH      = c_DEF_DEPTH
) (
    input  logic                    CLK50,
    input  logic                    MSS_RESET_N,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    clr,
    input  logic [NCH-1:0]          adc_din,
    output logic                    CS,
    output logic                    SCLK,
    output logic [NCH*SAMPLE_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    overflow,
    output logic [15:0]             frame_cnt
);
    localparam int c_W       = NCH * SAMPLE_W;
    localparam int c_CNT_MAX = (2 * CLKDIV > QUIET_CYC) ? 2 * CLKDIV : QUIET_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W   = $clog2(FRAME_BITS + 1);

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic               r_cs, w_cs_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               w_sample;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               r_overflow;
    logic [15:0]        r_frame_cnt;
    logic [c_W-1:0]     w_word;

    assign CS        = r_cs;
    assign SCLK      = r_sclk;
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;
    assign frame_cnt = r_frame_cnt;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_cs    <= w_cs_nxt;
            r_sclk  <= w_sclk_nxt;
        end
    end

    // CS/SCLK are computed one cycle ahead so the pins come straight from flops
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_cs_nxt    = r_cs;
        w_sclk_nxt  = r_sclk;
        w_sample    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (start || cont) begin
                    w_state_nxt = ST_SETUP;
                    w_cs_nxt    = 1'b0;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_CNT_W'(CLKDIV - 1)) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_CNT_W'(CLKDIV - 1)) begin
                    w_sclk_nxt = 1'b1;
                    w_sample   = 1'b1;
                end
                if (r_cnt == c_CNT_W'(2 * CLKDIV - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_bit == c_BIT_W'(FRAME_BITS - 1)) begin
                        w_state_nxt = ST_QUIET;
                        w_cs_nxt    = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        w_bit_nxt  = r_bit + c_BIT_W'(1);
                    end
                end
            end
            ST_QUIET: begin
                if (r_cnt == c_CNT_W'(QUIET_CYC - 1)) begin
                    w_state_nxt = ST_PUSH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PUSH: begin
                w_push    = 1'b1;
                w_cnt_nxt = '0;
                if (cont) begin
                    w_state_nxt = ST_SETUP;
                    w_cs_nxt    = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_cs_nxt    = 1'b1;
                w_sclk_nxt  = 1'b1;
            end
        endcase
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [FRAME_BITS-1:0] r_shift;

        always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
            if (!MSS_RESET_N)  r_shift <= '0;
            else if (w_sample) r_shift <= {r_shift[FRAME_BITS-2:0], adc_din[gi]};
        end

        assign w_word[gi*SAMPLE_W +: SAMPLE_W] =
            SAMPLE_W'(frame_field(64'(r_shift), FRAME_BITS - 1 - LEAD_BITS, SAMPLE_W));
    end

    // A push into a full buffer only lands when a pop frees the head slot
    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_push) begin
            if (w_full && !w_pop) r_overflow  <= 1'b1;
            else                  r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    adc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_W)
    ) u_fifo (
        .clk     (CLK50),
        .rst_n   (MSS_RESET_N),
        .i_clr   (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_word),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_full  (w_full)
    );

endmodule
`default_nettype wire
